// File: rtl/pool_2d_param.sv
// 2x2 stride-2 max/average pooling over CH back-to-back feature maps.
// Streams one read per cycle from the input RAM and writes one result per window.
module pool_2d_param #(
  parameter int DW   = 12,
  parameter int IN_W = 10,
  parameter int IN_H = 10,
  parameter int CH   = 1,
  parameter int RAW  = $clog2(CH*IN_W*IN_H),
  parameter int WAW  = $clog2(CH*IN_W*IN_H/4)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [RAW-1:0] rd_addr,
  input  logic [DW-1:0]  rd_dout,
  output logic           wr_en,
  output logic [WAW-1:0] wr_addr,
  output logic [DW-1:0]  wr_din
);
  localparam int OUT_W = IN_W/2;
  localparam int OUT_H = IN_H/2;
  localparam int N     = 4*CH*OUT_W*OUT_H;
  localparam int CW    = $clog2(CH+1);
  localparam int RW    = $clog2(OUT_H+1);
  localparam int OCW   = $clog2(OUT_W+1);
  localparam int NW    = $clog2(N+1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             drn_q, drn_d, mode_q, mode_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [RAW-1:0]   rd_addr_q, rd_addr_d;
  logic [WAW-1:0]   wr_addr_q, wr_addr_d, wr_cnt_q, wr_cnt_d;
  logic [DW-1:0]    wr_din_q, wr_din_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [RW-1:0]    orow_q, orow_d;
  logic [OCW-1:0]   ocol_q, ocol_d;
  logic [1:0]       sub_q, sub_d, dsub_q, dsub_d;
  logic [NW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             dvld_q, dvld_d;
  logic [DW+1:0]    acc_q, acc_d, acc_new, din_x;

  function automatic logic [RAW-1:0] addr_of(input logic [CW-1:0] c, input logic [RW-1:0] r,
                                             input logic [OCW-1:0] o, input logic [1:0] s);
    addr_of = RAW'(int'(c)*IN_W*IN_H + (2*int'(r) + int'(s[1]))*IN_W + 2*int'(o) + int'(s[0]));
  endfunction

  always_comb begin
    state_d   = state_q;
    drn_d     = drn_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_din_d  = wr_din_q;
    wr_cnt_d  = wr_cnt_q;
    ch_d      = ch_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    sub_d     = sub_q;
    rd_cnt_d  = rd_cnt_q;
    acc_d     = acc_q;
    acc_new   = acc_q;
    din_x     = {2'b00, rd_dout};

    // RAM data lags the strobe by one cycle; the sample's window slot travels with it.
    dvld_d = rd_en_q;
    dsub_d = sub_q;
    if (dvld_q) begin
      if (dsub_q == 2'd0)  acc_new = din_x;
      else if (mode_q)     acc_new = acc_q + din_x;
      else                 acc_new = (din_x > acc_q) ? din_x : acc_q;
      acc_d = acc_new;
      if (dsub_q == 2'd3) begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_cnt_q;
        wr_din_d  = mode_q ? acc_new[DW+1:2] : acc_new[DW-1:0];
        wr_cnt_d  = wr_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: if (start) begin
        state_d   = RUN;
        mode_d    = mode;
        busy_d    = 1'b1;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
        ch_d      = '0;
        orow_d    = '0;
        ocol_d    = '0;
        sub_d     = '0;
        rd_cnt_d  = '0;
        wr_cnt_d  = '0;
      end
      RUN: if (rd_cnt_q == NW'(N-1)) begin
        state_d = DRAIN;
        drn_d   = 1'b0;
      end else begin
        rd_en_d  = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        sub_d    = sub_q + 2'd1;
        if (sub_q == 2'd3) begin
          ocol_d = ocol_q + 1'b1;
          if (ocol_q == OCW'(OUT_W-1)) begin
            ocol_d = '0;
            orow_d = orow_q + 1'b1;
            if (orow_q == RW'(OUT_H-1)) begin
              orow_d = '0;
              ch_d   = ch_q + 1'b1;
            end
          end
        end
        rd_addr_d = addr_of(ch_d, orow_d, ocol_d, sub_d);
      end
      // Two cycles let the final sample land and its result be written.
      DRAIN: if (drn_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        drn_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      drn_q     <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_din_q  <= '0;
      wr_cnt_q  <= '0;
      ch_q      <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      sub_q     <= '0;
      rd_cnt_q  <= '0;
      dvld_q    <= 1'b0;
      dsub_q    <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      drn_q     <= drn_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_din_q  <= wr_din_d;
      wr_cnt_q  <= wr_cnt_d;
      ch_q      <= ch_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      sub_q     <= sub_d;
      rd_cnt_q  <= rd_cnt_d;
      dvld_q    <= dvld_d;
      dsub_q    <= dsub_d;
      acc_q     <= acc_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_din  = wr_din_q;
endmodule

// File: tb/tb_pool_2d_param.sv
// Bench for pool_2d_param: one single-channel and one dual-channel 4x4 instance,
// both fed from a shared 32-word RAM model and compared against a window-level model.
module tb_pool_2d_param;
  logic        clk, rst, start, mode_in, sel;
  logic [11:0] mem [0:31];

  logic        a_busy, a_done, a_rd_en, a_wr_en;
  logic [3:0]  a_rd_addr;
  logic [1:0]  a_wr_addr;
  logic [11:0] a_rd_dout, a_wr_din;
  logic        b_busy, b_done, b_rd_en, b_wr_en;
  logic [4:0]  b_rd_addr;
  logic [2:0]  b_wr_addr;
  logic [11:0] b_rd_dout, b_wr_din;

  int checks = 0;
  int errors = 0;
  int exp_rd[$];
  int exp_wr[$];

  pool_2d_param #(.DW(12), .IN_W(4), .IN_H(4), .CH(1)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .mode(mode_in), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_dout(a_rd_dout),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_din(a_wr_din));

  pool_2d_param #(.DW(12), .IN_W(4), .IN_H(4), .CH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .mode(mode_in), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_dout(b_rd_dout),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_din(b_wr_din));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_rd_en) a_rd_dout <= mem[a_rd_addr];
    if (b_rd_en) b_rd_dout <= mem[b_rd_addr];
  end

  logic        m_busy, m_done, m_rd_en, m_wr_en;
  logic [7:0]  m_rd_addr, m_wr_addr;
  logic [11:0] m_wr_din;
  always_comb begin
    m_busy    = sel ? b_busy    : a_busy;
    m_done    = sel ? b_done    : a_done;
    m_rd_en   = sel ? b_rd_en   : a_rd_en;
    m_wr_en   = sel ? b_wr_en   : a_wr_en;
    m_rd_addr = sel ? 8'(b_rd_addr) : 8'(a_rd_addr);
    m_wr_addr = sel ? 8'(b_wr_addr) : 8'(a_wr_addr);
    m_wr_din  = sel ? b_wr_din  : a_wr_din;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Reference: 4x4 maps, windows in channel/row/column order.
  task automatic build_model(input int nch, input bit md);
    exp_rd.delete();
    exp_wr.delete();
    for (int c = 0; c < nch; c++)
      for (int r = 0; r < 2; r++)
        for (int o = 0; o < 2; o++) begin
          int a0, mx, sum;
          int px[4];
          a0 = c*16 + 2*r*4 + 2*o;
          px[0] = int'(mem[a0]);   px[1] = int'(mem[a0+1]);
          px[2] = int'(mem[a0+4]); px[3] = int'(mem[a0+5]);
          exp_rd.push_back(a0);   exp_rd.push_back(a0+1);
          exp_rd.push_back(a0+4); exp_rd.push_back(a0+5);
          mx = 0; sum = 0;
          for (int i = 0; i < 4; i++) begin
            sum += px[i];
            if (px[i] > mx) mx = px[i];
          end
          exp_wr.push_back(md ? sum / 4 : mx);
        end
  endtask

  // Called positioned just after a falling edge; drives start there (cycle 0).
  task automatic run_op(input bit s, input bit md, input int nch, input string tag, input bit hold);
    int n, k, done_k, first_rd, last_wr, nwr;
    int rd_q[$];
    int wa_q[$];
    int wd_q[$];
    build_model(nch, md);
    n = 4*nch*4;
    sel = s; mode_in = md; start = 1'b1;
    done_k = -1; first_rd = -1; last_wr = -1;
    for (k = 1; k <= n + 20; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (m_rd_en) begin
        rd_q.push_back(int'(m_rd_addr));
        if (first_rd < 0) first_rd = k;
      end
      if (m_wr_en) begin
        wa_q.push_back(int'(m_wr_addr));
        wd_q.push_back(int'(m_wr_din));
        last_wr = k;
      end
      if (m_done) begin
        done_k = k;
        chk({tag, "_busy_at_done"}, 32'(m_busy), 0);
        break;
      end
    end
    chk({tag, "_done_cycle"}, done_k, n + 3);
    chk({tag, "_first_rd"}, first_rd, 1);
    chk({tag, "_rd_count"}, rd_q.size(), n);
    for (int i = 0; i < rd_q.size() && i < n; i++)
      chk($sformatf("%s_rd_addr%0d", tag, i), rd_q[i], exp_rd[i]);
    nwr = wa_q.size();
    chk({tag, "_wr_count"}, nwr, n/4);
    chk({tag, "_last_wr"}, last_wr, n + 2);
    for (int i = 0; i < nwr && i < n/4; i++) begin
      chk($sformatf("%s_wr_addr%0d", tag, i), wa_q[i], i);
      chk($sformatf("%s_wr_data%0d", tag, i), wd_q[i], exp_wr[i]);
    end
  endtask

  task automatic fill_addr(input int off);
    for (int i = 0; i < 32; i++) mem[i] = 12'(i + off);
  endtask

  initial begin
    int nbad;
    rst = 1'b1; start = 1'b0; mode_in = 1'b0; sel = 1'b0;
    fill_addr(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(a_busy | b_busy), 0);
    chk("rst_done",   32'(a_done | b_done), 0);
    chk("rst_rd_en",  32'(a_rd_en | b_rd_en), 0);
    chk("rst_wr_en",  32'(a_wr_en | b_wr_en), 0);
    chk("rst_addr",   32'({a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr}), 0);
    chk("rst_wr_din", 32'({a_wr_din, b_wr_din}), 0);
    rst = 1'b0;

    // Start accepted on the very first cycle after release.
    run_op(0, 0, 1, "max_ramp", 0);
    chk("max_ramp_w0", exp_wr[0], 5);
    run_op(0, 1, 1, "avg_ramp", 0);
    chk("avg_ramp_w0", exp_wr[0], 2);

    for (int i = 0; i < 32; i++) mem[i] = 12'hFFF;
    run_op(0, 1, 1, "avg_full", 0);
    run_op(0, 0, 1, "max_full", 0);
    run_op(1, 1, 2, "avg_full2", 0);

    fill_addr(0);
    run_op(1, 0, 2, "max_ch2", 0);
    chk("max_ch2_w4", exp_wr[4], 21);

    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 32; i++) mem[i] = 12'($urandom_range(0, 4095));
      run_op(0, it[0], 1, $sformatf("rnd_a%0d", it), 0);
      run_op(1, ~it[0], 2, $sformatf("rnd_b%0d", it), 0);
    end

    // Reset asserted during cycle 6 of a run.
    fill_addr(0);
    sel = 1'b0; mode_in = 1'b0; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy",  32'(a_busy), 0);
    chk("midrst_rd_en", 32'(a_rd_en), 0);
    chk("midrst_wr",    32'({a_wr_en, a_wr_addr, a_wr_din}), 0);
    rst = 1'b0;
    nbad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (a_wr_en || a_done || a_busy || a_rd_en) nbad++;
    end
    chk("midrst_quiet", nbad, 0);
    run_op(0, 0, 1, "after_rst", 0);

    // start held high: one full run, then a second accepted at done.
    run_op(0, 0, 1, "hold", 1);
    @(negedge clk);
    chk("hold_rerun_busy",  32'(a_busy), 1);
    chk("hold_rerun_rd_en", 32'(a_rd_en), 1);
    chk("hold_rerun_addr",  32'(a_rd_addr), 0);
    start = 1'b0;
    nbad = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_done) begin nbad = 0; break; end
    end
    chk("hold_rerun_done", nbad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
